// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode and FSM state encodings,
// plus the helper that separates single-cycle ops from the iterative
// multiply/divide ops.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_SLL   = 4'h4,
    OP_SLT   = 4'h5,
    OP_PASSB = 4'h6,
    OP_XOR   = 4'h7,
    OP_SRL   = 4'h8,
    OP_SRA   = 4'h9,
    OP_SLTU  = 4'hA,
    OP_MUL   = 4'hB,
    OP_MULHU = 4'hC,
    OP_DIVU  = 4'hD,
    OP_REMU  = 4'hE,
    OP_RSVD  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_iterative(input alu_op_e op);
    return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / divide unit, one bit per cycle.
// A single hi/lo register pair and one down-counter serve both operations:
//   multiply: {hi,lo} is the shift-add product register, lo starts as b.
//   divide:   hi is the partial remainder, lo shifts out the dividend and
//             shifts in quotient bits (restoring division).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   flush       abandon the current operation
//   start       load operands and begin (op must be MUL/MULHU/DIVU/REMU)
//   op          opcode (alu_op_e encoding)
//   a, b        operands (a = multiplicand/dividend, b = multiplier/divisor)
//   done        high in the cycle the final step is applied
//   result      selected half of {hi,lo}; final one cycle after done
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    r_cnt;
  alu_op_e          r_op;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_is_div;
  logic             w_start_div;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;

  assign w_is_div    = (r_op == OP_DIVU) || (r_op == OP_REMU);
  assign w_start_div = (alu_op_e'(op) == OP_DIVU) || (alu_op_e'(op) == OP_REMU);

  // Multiply step: conditionally add the multiplicand into the high half,
  // keeping the carry so the whole product shifts right by one.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

  // Divide step: bring the next dividend bit into the remainder and try the
  // subtraction. A divisor of zero always "fits", which yields an all-ones
  // quotient and leaves the dividend as remainder without special casing.
  assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_opnd};

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, so the result seen through
    // the top-level output is 0 immediately on reset, not stale data.
    if (!rst_n) begin
      r_cnt  <= '0;
      r_op   <= OP_MUL;
      r_opnd <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt  <= CW'(WIDTH);
      r_op   <= alu_op_e'(op);
      r_hi   <= '0;
      r_opnd <= w_start_div ? b : a;
      r_lo   <= w_start_div ? a : b;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      if (w_is_div) begin
        if (!w_diff[WIDTH]) begin
          r_hi <= w_diff[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_rem_sh[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_mul_sum[WIDTH:1];
        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign done   = (r_cnt == CW'(1));
  assign result = (r_op == OP_MULHU || r_op == OP_REMU) ? r_hi : r_lo;

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU. Single-cycle ops produce a registered result
// one cycle after accept; MUL/MULHU/DIVU/REMU run in alu_muldiv_iter for
// WIDTH cycles and stall the input side until the result is consumed.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous abort, back to IDLE
//   in_valid / in_ready   operand handshake
//   PC, RD1 / RD2, ImmExt SrcA / SrcB candidates, chosen by ALUSrcA / ALUSrcB
//   ALUControl            opcode (alu_op_e)
//   out_valid / out_ready result handshake
//   ALUResult, Zero       result and result==0 flag
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic [WIDTH-1:0] ImmExt,
  input  logic             ALUSrcA,
  input  logic             ALUSrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int SHW = $clog2(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_use_iter;

  alu_op_e          w_op;
  logic [WIDTH-1:0] w_src_a;
  logic [WIDTH-1:0] w_src_b;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_comb;
  logic [WIDTH-1:0] w_iter_result;
  logic             w_accept;
  logic             w_iter_start;
  logic             w_iter_done;

  assign w_op    = alu_op_e'(ALUControl);
  assign w_src_a = ALUSrcA ? PC : RD1;
  assign w_src_b = ALUSrcB ? ImmExt : RD2;
  assign w_shamt = w_src_b[SHW-1:0];

  // NOTE: the default assignment first means every path writes w_comb, so no
  // latch is inferred even for opcodes handled elsewhere.
  always_comb begin
    w_comb = '0;
    case (w_op)
      OP_ADD:   w_comb = w_src_a + w_src_b;
      OP_SUB:   w_comb = w_src_a - w_src_b;
      OP_AND:   w_comb = w_src_a & w_src_b;
      OP_OR:    w_comb = w_src_a | w_src_b;
      OP_XOR:   w_comb = w_src_a ^ w_src_b;
      OP_SLL:   w_comb = w_src_a << w_shamt;
      OP_SRL:   w_comb = w_src_a >> w_shamt;
      OP_SRA:   w_comb = $signed(w_src_a) >>> w_shamt;
      OP_SLT:   w_comb = {{(WIDTH-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      OP_SLTU:  w_comb = {{(WIDTH-1){1'b0}}, (w_src_a < w_src_b)};
      OP_PASSB: w_comb = w_src_b;
      default:  w_comb = '0;
    endcase
  end

  // DONE & out_ready frees the slot in the same cycle, allowing back-to-back issue.
  assign in_ready     = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept     = in_valid && in_ready && !flush;
  assign w_iter_start = w_accept && is_iterative(w_op);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (w_iter_start),
    .op     (ALUControl),
    .a      (w_src_a),
    .b      (w_src_b),
    .done   (w_iter_done),
    .result (w_iter_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_result   <= '0;
      r_use_iter <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
    end else if (w_accept) begin
      if (is_iterative(w_op)) begin
        r_state    <= BUSY;
        r_use_iter <= 1'b1;
      end else begin
        r_state    <= DONE;
        r_result   <= w_comb;
        r_use_iter <= 1'b0;
      end
    end else begin
      case (r_state)
        BUSY:    if (w_iter_done) r_state <= DONE;
        DONE:    if (out_ready)   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The iterative unit's registers go quiet once its counter reaches zero,
  // so selecting them holds the result stable while DONE waits for out_ready.
  assign out_valid = (r_state == DONE);
  assign ALUResult = r_use_iter ? w_iter_result : r_result;
  assign Zero      = (ALUResult == '0);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] PC, RD1, RD2, ImmExt, ALUResult;
  logic        ALUSrcA, ALUSrcB, Zero;
  logic [3:0]  ALUControl;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .PC(PC), .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour written directly from the opcode definitions.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          sh;
    p  = {32'b0, a} * {32'b0, b};
    sh = int'(b[4:0]);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a << sh;
      4'h5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h6: return b;
      4'h7: return a ^ b;
      4'h8: return a >> sh;
      4'h9: return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'hA: return (a < b) ? 32'd1 : 32'd0;
      4'hB: return p[31:0];
      4'hC: return p[63:32];
      4'hD: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hE: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit op_is_iter(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: one entry per accepted op, due 1 or WIDTH+1 cycles later.
  always @(negedge clk) begin
    bit exp_v;
    cyc++;
    if (!rst_n) begin
      sb.delete();
    end else begin
      exp_v = (sb.size() > 0) && (cyc >= sb[0].due);
      check("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v && out_valid) begin
        check("model_result", ALUResult, sb[0].res);
        check("model_zero", 32'(Zero), 32'(sb[0].res == 32'd0));
        if (out_ready) void'(sb.pop_front());
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back('{res: model(ALUControl, ALUSrcA ? PC : RD1, ALUSrcB ? ImmExt : RD2),
                       due: cyc + (op_is_iter(ALUControl) ? 33 : 1)});
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb_sel);
    ALUControl = op;
    ALUSrcA    = sa;
    ALUSrcB    = sb_sel;
    PC     = sa ? a : ~a;
    RD1    = sa ? ~a : a;
    ImmExt = sb_sel ? b : ~b;
    RD2    = sb_sel ? ~b : b;
    in_valid = 1'b1;
  endtask

  // Returns at #1 after the accepting edge with operands scrambled.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb_sel);
    int k = 0;
    drive(op, a, b, sa, sb_sel);
    forever begin
      @(negedge clk);
      if (in_ready && !flush) break;
      k++;
      if (k > 100) begin
        check("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    PC = $urandom; RD1 = $urandom; RD2 = $urandom; ImmExt = $urandom;
    ALUControl = 4'($urandom);
  endtask

  task automatic wait_valid(input int max, output int lat, output int rdy_hits);
    lat = 0;
    rdy_hits = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) rdy_hits++;
      if (lat >= max) begin
        check("valid_timeout", 32'(out_valid), 32'd1);
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic sa, input logic sb_sel,
                        input logic [31:0] exp);
    int lat, hits;
    issue(op, a, b, sa, sb_sel);
    wait_valid(60, lat, hits);
    check({name, "_result"}, ALUResult, exp);
    check({name, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
    check({name, "_latency"}, lat, op_is_iter(op) ? 32'd33 : 32'd1);
    if (op_is_iter(op)) check({name, "_in_ready_busy"}, hits, 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        sa, sb;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int   n_v;
    vecs.push_back('{"sra",    OP_SRA,   32'h8000_0000, 32'd4,         0, 1, 32'hF800_0000});
    vecs.push_back('{"slt",    OP_SLT,   32'hFFFF_FFFF, 32'd1,         0, 0, 32'd1});
    vecs.push_back('{"sltu",   OP_SLTU,  32'hFFFF_FFFF, 32'd1,         0, 0, 32'd0});
    vecs.push_back('{"sub_eq", OP_SUB,   32'd9,         32'd9,         0, 0, 32'd0});
    vecs.push_back('{"and",    OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 32'hF000_F000});
    vecs.push_back('{"or",     OP_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 32'hFFF0_FFF0});
    vecs.push_back('{"xor",    OP_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 32'h0FF0_0FF0});
    vecs.push_back('{"sll31",  OP_SLL,   32'd1,         32'd31,        0, 0, 32'h8000_0000});
    vecs.push_back('{"sll_wr", OP_SLL,   32'd1,         32'h21,        0, 0, 32'd2});
    vecs.push_back('{"srl",    OP_SRL,   32'h8000_0000, 32'd4,         0, 0, 32'h0800_0000});
    vecs.push_back('{"passb",  OP_PASSB, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 32'h1234_5678});
    vecs.push_back('{"pc_add", OP_ADD,   32'h0000_1000, 32'd4,         1, 1, 32'h0000_1004});
    vecs.push_back('{"rsvd",   OP_RSVD,  32'd3,         32'd4,         0, 0, 32'd0});
    vecs.push_back('{"mul",    OP_MUL,   32'hFFFF_FFFF, 32'd2,         0, 0, 32'hFFFF_FFFE});
    vecs.push_back('{"mulhu",  OP_MULHU, 32'hFFFF_FFFF, 32'd2,         0, 0, 32'h0000_0001});
    vecs.push_back('{"mul2",   OP_MUL,   32'd12345,     32'd678,       0, 1, 32'h007F_B6F6});
    vecs.push_back('{"divu",   OP_DIVU,  32'd100,       32'd7,         0, 0, 32'd14});
    vecs.push_back('{"remu",   OP_REMU,  32'd100,       32'd7,         0, 0, 32'd2});
    vecs.push_back('{"divu0",  OP_DIVU,  32'd5,         32'd0,         0, 0, 32'hFFFF_FFFF});
    vecs.push_back('{"remu0",  OP_REMU,  32'd100,       32'd0,         0, 0, 32'd100});

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    PC = '0; RD1 = '0; RD2 = '0; ImmExt = '0; ALUSrcA = 1'b0; ALUSrcB = 1'b0; ALUControl = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", 32'(Zero), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Back-to-back ADD then SUB with out_ready held high.
    issue(OP_ADD, 32'd7, 32'd5, 1'b0, 1'b0);
    drive(OP_SUB, 32'd5, 32'd7, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_add_valid", 32'(out_valid), 32'd1);
    check("b2b_add_result", ALUResult, 32'h0000_000C);
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_sub_valid", 32'(out_valid), 32'd1);
    check("b2b_sub_result", ALUResult, 32'hFFFF_FFFE);
    @(posedge clk); #1;

    // Directed table.
    n_v = vecs.size();
    for (int i = 0; i < n_v; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, vecs[i].exp);

    // Hold DONE with out_ready low for 5 cycles.
    begin
      int lat, hits;
      out_ready = 1'b0;
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
      wait_valid(60, lat, hits);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_result", ALUResult, 32'd14);
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_released", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Flush during the 10th cycle of a MUL, with a competing op presented.
    begin
      int seen = 0;
      issue(OP_MUL, 32'd3, 32'd5, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      drive(OP_ADD, 32'd2, 32'd2, 1'b0, 1'b0);
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("flush_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("flush_no_valid", seen, 32'd0);
      @(posedge clk); #1;
    end

    // Flush in IDLE: the accept in the flush cycle is dropped.
    begin
      int seen = 0;
      drive(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0);
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("flush_idle_drop", seen, 32'd0);
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a DIVU.
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", ALUResult, 32'd0);
    check("midrst_zero", 32'(Zero), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    run_op("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14);
    run_op("post_rst_add", OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
